// File: rtl/delay_line_pkg.sv
// Shared constants and the width helper for the delay_line sample memory.
package delay_line_pkg;

  localparam int DL_DEPTH_MIN = 2;
  localparam int DL_DEPTH_MAX = 64;
  localparam int DL_N_DEFAULT = 16;

  function automatic int dl_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One N-bit signed storage stage: reset, then clear, then enable.
module delay_stage #(
  parameter int N = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic signed [N-1:0] d_i,
  output logic signed [N-1:0] q_o
);

  logic signed [N-1:0] data_q;
  logic signed [N-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/delay_line.sv
// DEPTH-stage signed delay line with fill tracking and a run-time tap mux.
// Defining DELAY_LINE_TAPS_EN adds the flattened taps output.
module delay_line
  import delay_line_pkg::*;
#(
  parameter  int N     = DL_N_DEFAULT,
  parameter  int DEPTH = 4,
  localparam int SW    = (dl_clog2(DEPTH) > 1) ? dl_clog2(DEPTH) : 1,
  localparam int FW    = dl_clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                clr,
  input  logic signed [N-1:0] d,
  input  logic [SW-1:0]       sel,
  output logic signed [N-1:0] q,
  output logic                q_valid,
  output logic                full,
  output logic [FW-1:0]       fill
`ifdef DELAY_LINE_TAPS_EN
  ,
  output logic [N*DEPTH-1:0]  taps
`endif
);

  if (DEPTH < DL_DEPTH_MIN || DEPTH > DL_DEPTH_MAX) begin : g_depth_check
    $error("delay_line: DEPTH out of legal range");
  end

  logic signed [N-1:0] stage [DEPTH];
  logic [FW-1:0]       fill_q;
  logic [FW-1:0]       fill_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic signed [N-1:0] stage_in;
    if (gi == 0) begin : g_head
      assign stage_in = d;
    end else begin : g_body
      assign stage_in = stage[gi-1];
    end

    delay_stage #(.N(N)) u_stage (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (clr),
      .en_i  (en),
      .d_i   (stage_in),
      .q_o   (stage[gi])
    );

`ifdef DELAY_LINE_TAPS_EN
    assign taps[N*gi +: N] = stage[gi];
`endif
  end

  // Fill saturates at DEPTH so that full stays asserted while streaming.
  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (en && (fill_q != FW'(DEPTH))) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Out-of-range sel (non power-of-2 DEPTH) matches no stage and yields 0.
  always_comb begin
    q = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == SW'(k)) q = stage[k];
    end
  end

  assign q_valid = (int'(sel) < DEPTH) && (int'(fill_q) > int'(sel));
  assign full    = (fill_q == FW'(DEPTH));
  assign fill    = fill_q;

endmodule

// File: tb/tb_delay_line.sv
// Directed-vector bench for delay_line: DEPTH=4 and DEPTH=3 instances.
module tb_delay_line;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clr = 1'b0;

  logic        en4 = 1'b0;
  logic [15:0] d4  = '0;
  logic [1:0]  sel4 = '0;
  logic [15:0] q4;
  logic        qv4, full4;
  logic [2:0]  fill4;

  logic        en3 = 1'b0;
  logic [15:0] d3  = '0;
  logic [1:0]  sel3 = '0;
  logic [15:0] q3;
  logic        qv3, full3;
  logic [1:0]  fill3;

`ifdef DELAY_LINE_TAPS_EN
  logic [63:0] taps4;
  logic [47:0] taps3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  delay_line #(.N(16), .DEPTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .en(en4), .clr(clr), .d(d4), .sel(sel4),
    .q(q4), .q_valid(qv4), .full(full4), .fill(fill4)
`ifdef DELAY_LINE_TAPS_EN
    , .taps(taps4)
`endif
  );

  delay_line #(.N(16), .DEPTH(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .en(en3), .clr(clr), .d(d3), .sel(sel3),
    .q(q3), .q_valid(qv3), .full(full3), .fill(fill3)
`ifdef DELAY_LINE_TAPS_EN
    , .taps(taps3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check4(input string tag, input logic [15:0] eq, input logic eqv,
                        input logic [2:0] efill, input logic efull);
    check({tag, ".q"}, 64'(q4), 64'(eq));
    check({tag, ".q_valid"}, 64'(qv4), 64'(eqv));
    check({tag, ".fill"}, 64'(fill4), 64'(efill));
    check({tag, ".full"}, 64'(full4), 64'(efull));
  endtask

  logic [15:0] exp_q3 [4];
  logic        exp_v3 [4];

  initial begin
    // reset and idle
    sel4 = 2'd3;
    step();
    check4("rst1", 16'h0, 1'b0, 3'd0, 1'b0);
    step();
    check4("rst2", 16'h0, 1'b0, 3'd0, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check4($sformatf("idle%0d", i), 16'h0, 1'b0, 3'd0, 1'b0);
    end

    // fill and shift with sel=3: d=1..5
    en4 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      d4 = 16'(i);
      step();
      check4($sformatf("fill%0d", i),
             (i == 4) ? 16'd1 : (i == 5) ? 16'd2 : 16'd0,
             (i >= 4), (i >= 4) ? 3'd4 : 3'(i), (i >= 4));
    end

    // enable gating: accept -7, then idle while d toggles
    d4 = 16'hFFF9;
    step();
    en4 = 1'b0;
    sel4 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      d4 = (i % 2 == 0) ? 16'h1234 : 16'h00AA;
      step();
      check4($sformatf("hold%0d", i), 16'hFFF9, 1'b1, 3'd4, 1'b1);
    end
    sel4 = 2'd1; #1;
    check("hold.sel1", 64'(q4), 64'd5);
    sel4 = 2'd3; #1;
    check("hold.sel3", 64'(q4), 64'd3);

    // clear beats enable; d=9 discarded
    clr = 1'b1; en4 = 1'b1; d4 = 16'd9;
    step();
    clr = 1'b0; en4 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s); #1;
      check4($sformatf("clr.sel%0d", s), 16'h0, 1'b0, 3'd0, 1'b0);
    end
`ifdef DELAY_LINE_TAPS_EN
    check("clr.taps", taps4, 64'h0);
`endif
    en4 = 1'b1; d4 = 16'd11;
    step();
    en4 = 1'b0;
    sel4 = 2'd0; #1;
    check4("restart.sel0", 16'd11, 1'b1, 3'd1, 1'b0);
    sel4 = 2'd1; #1;
    check("restart.sel1.q_valid", 64'(qv4), 64'd0);

    // DEPTH=3 dynamic sel sweep
    en3 = 1'b1;
    d3 = 16'd10; step();
    d3 = 16'd20; step();
    d3 = 16'd30; step();
    en3 = 1'b0;
    exp_q3 = '{16'd30, 16'd20, 16'd10, 16'd0};
    exp_v3 = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      sel3 = 2'(s); #1;
      check($sformatf("d3.sel%0d.q", s), 64'(q3), 64'(exp_q3[s]));
      check($sformatf("d3.sel%0d.q_valid", s), 64'(qv3), 64'(exp_v3[s]));
    end
    check("d3.fill", 64'(fill3), 64'd3);
    check("d3.full", 64'(full3), 64'd1);
    en3 = 1'b1; d3 = 16'd40;
    step();
    en3 = 1'b0;
    sel3 = 2'd2; #1;
    check("d3.sat.fill", 64'(fill3), 64'd3);
    check("d3.sat.q", 64'(q3), 64'd20);

`ifdef DELAY_LINE_TAPS_EN
    clr = 1'b1; step(); clr = 1'b0;
    en4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d4 = 16'(i);
      step();
    end
    en4 = 1'b0;
    check("taps4", taps4, 64'h0001_0002_0003_0004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_line.md
# delay_line

Parametrised N-bit signed delay line with clock-enable, synchronous clear, fill tracking and a run-time selectable tap. Generalises the single-stage signed register used throughout the IIR datapath into a DEPTH-stage sample memory. Feedback and feedforward paths can take z^-1 … z^-DEPTH from one instance. It sits between the sample-rate strobe generator and the coefficient multipliers.

## Interface
- N, 16, sample width in bits (signed two's complement)
- DEPTH, 4, number of delay stages; legal range 2..64
- SW, derived = max(1, clog2(DEPTH)), width of sel
- FW, derived = clog2(DEPTH+1), width of fill

- CLK  input  1  clock
- RST  input  1  reset; one clock, synchronous, active-high
- en  input  1  sample strobe; shift occurs on a rising CLK edge with en=1
- clr  input  1  synchronous flush of all stages and fill count
- d  input  N  signed input sample
- sel  input  SW  tap select; sel=k selects a delay of k+1 accepted samples
- q  output  N  signed contents of stage[sel]
- q_valid  output  1  stage[sel] holds a real sample (fill > sel)
- full  output  1  fill == DEPTH
- fill  output  FW  accepted samples since reset/clr, saturating at DEPTH
- taps  output  N*DEPTH  all stages flattened; stage[k] at bits [N*k +: N] (only with DELAY_LINE_TAPS_EN)

## Operation
- Storage: stage[0..DEPTH-1], each N bits signed.
- Priority per edge: RST > clr > en > hold.
- RST=1: all stages 0, fill 0.
- clr=1 (RST=0): all stages 0, fill 0. d is discarded even when en=1.
- en=1 (RST=0, clr=0):
  - stage[0] <= d; stage[k] <= stage[k-1] for k ≥ 1.
  - stage[DEPTH-1] contents are dropped.
  - fill <= min(fill+1, DEPTH).
- en=0: all state held; d ignored.
- Output selection:
  - q = stage[sel], combinational mux from registers.
  - q_valid = (sel < DEPTH) && (fill > sel).
  - If sel ≥ DEPTH (only possible when DEPTH is not a power of 2): q = 0, q_valid = 0.
- full = (fill == DEPTH). fill never wraps; en while full keeps fill=DEPTH.
- No arithmetic is applied to data. Values pass bit-exact, with sign preserved.
- Reset values: q=0, q_valid=0, full=0, fill=0, taps=0.

## Timing
- Sample d accepted at edge t (en=1) appears on stage[0] after edge t. With sel=0 it is visible on q in the same cycle.
- With sel=k, that sample reaches q after k+1 accepting edges. Idle (en=0) cycles do not advance it.
- q/q_valid respond to a sel change in the same cycle (no register in the sel path).
- fill/full/q_valid update on the same edge as the shift.
- clr or RST mid-fill: after that edge fill=0 and q_valid=0 for every sel. The next en restarts from stage[0].

## Configuration
- DELAY_LINE_TAPS_EN defined:
  - taps port exists and is driven from the stages every cycle (no extra latency).
  - Used for parallel FIR/IIR tap fan-out.
- DELAY_LINE_TAPS_EN undefined:
  - taps port is absent.
  - Only the muxed q path remains.
  - Behaviour of all other ports is identical.

## Structure
- Package delay_line_pkg holds:
  - the clog2 helper used to derive SW and FW;
  - the DEPTH legality bounds (DL_DEPTH_MIN=2, DL_DEPTH_MAX=64);
  - the default width constant DL_N_DEFAULT=16.
- One sub-module, delay_stage:
  - an N-bit signed register with synchronous active-high reset, clr and en, in that priority;
  - instantiated DEPTH times via generate.
- Fill counter, output mux and flag logic live in the top module.

## Test plan
- Reset/idle: RST=1 for 2 cycles, then en=0 for 5 cycles -> q=0, q_valid=0, fill=0, full=0 throughout.
- Fill and shift (N=16, DEPTH=4, sel=3):
  - Stimulus: en=1 with d=1,2,3,4,5.
  - q_valid rises after the 4th edge with q=1; after the 5th edge q=2.
  - fill reads 1,2,3,4,4; full=1 from the 4th edge.
- Enable gating:
  - Stimulus: d=-7 (0xFFF9) accepted, then en=0 for 3 cycles while d toggles.
  - Response: stage[0] stays 0xFFF9 and fill is unchanged; with sel=0, q=-7 for all 3 cycles.
- Clear precedence:
  - Stimulus: while full, assert clr=1 and en=1 with d=9.
  - Response: next cycle fill=0, all taps 0, q_valid=0; 9 is not captured.
- Dynamic sel with DEPTH=3:
  - Stimulus: after accepting 10,20,30, sweep sel=0,1,2,3.
  - Response: q=30,20,10,0 and q_valid=1,1,1,0, each in the same cycle as the sel change.
- Taps macro: build with DELAY_LINE_TAPS_EN, accept 0x0001..0x0004 -> taps = {0x0001,0x0002,0x0003,0x0004} (MSB stage first).
